// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared instruction width, field positions and dispatch state encoding
package wavegen_pkg;
    localparam int INSTR_W  = 128;
    localparam int SEG_LSB  = 4;
    localparam int SEG_MSB  = 19;
    localparam int LEN_LSB  = 32;
    localparam int LEN_MSB  = 57;
    localparam int ADDR_LSB = 64;
    localparam int ADDR_MSB = 96;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } dispatch_state_t;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH x 128-bit instruction queue; DISPATCH_LOOP_EN turns reads into a replaying index
module instr_fifo
    import wavegen_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_wr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic               i_pop,
    output logic [INSTR_W-1:0] o_head,
    output logic [AW:0]        o_level,
    output logic               o_full
);
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW:0]        r_level;
    logic               w_wr;

    // A full queue rejects the write before any same-cycle pop is considered
    assign w_wr    = i_wr & ~o_full;
    assign o_level = r_level;
    assign o_full  = (r_level == (AW+1)'(DEPTH));

    // Storage is not reset; only the pointers define what is valid
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;

    // Tail pointer
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_wr_ptr <= '0;
        else if (i_clear) r_wr_ptr <= '0;
        else if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;

`ifdef DISPATCH_LOOP_EN
    logic [AW-1:0] r_rd_idx;
    logic [AW:0]   w_idx_inc;

    assign w_idx_inc = {1'b0, r_rd_idx} + 1'b1;
    assign o_head    = r_mem[r_rd_idx];

    // Replay index wraps to entry 0 after the last stored entry
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_rd_idx <= '0;
        else if (i_clear) r_rd_idx <= '0;
        else if (i_pop) r_rd_idx <= (w_idx_inc >= r_level) ? '0 : w_idx_inc[AW-1:0];

    // Entries are never freed by a read, so occupancy only grows until a clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_level <= '0;
        else if (i_clear) r_level <= '0;
        else r_level <= r_level + (AW+1)'(w_wr);
`else
    logic [AW-1:0] r_rd_ptr;

    assign o_head = r_mem[r_rd_ptr];

    // Head pointer advances on every pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_rd_ptr <= '0;
        else if (i_clear) r_rd_ptr <= '0;
        else if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

    // Occupancy: simultaneous accepted write and pop cancel out
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_level <= '0;
        else if (i_clear) r_level <= '0;
        else r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(i_pop);
`endif
endmodule

// File: rtl/cpu_instr_dispatch.sv
// cpu_instr_dispatch: host word staging, instruction queue and one-at-a-time issue to the executor (option: DISPATCH_LOOP_EN)
module cpu_instr_dispatch
    import wavegen_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        host_wdata,
    input  logic [1:0]         host_wsel,
    input  logic               host_wen,
    input  logic               host_clear,
    input  logic               run,
    input  logic               generate_done,
    output logic [INSTR_W-1:0] instrcution,
    output logic               instrc_valid,
    output logic [AW:0]        level,
    output logic               full,
    output logic               overflow,
    output logic [15:0]        drop_cnt,
    output logic               busy
);
    dispatch_state_t    r_state;
    logic [95:0]        r_stage;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_overflow;
    logic [15:0]        r_drop;
    logic [INSTR_W-1:0] w_head;
    logic               w_commit;
    logic               w_act;
    logic               w_seg_zero;

    assign w_commit     = host_wen & (host_wsel == 2'd3);
    assign w_act        = (r_state == S_IDLE) & run & (level != '0) & generate_done;
    assign w_seg_zero   = (w_head[SEG_MSB:SEG_LSB] == '0);
    assign instrcution  = r_instr;
    assign instrc_valid = r_valid;
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop;
    assign busy         = (r_state != S_IDLE);

    instr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (host_clear),
        .i_wr    (w_commit),
        .i_wdata ({host_wdata, r_stage}),
        .i_pop   (w_act),
        .o_head  (w_head),
        .o_level (level),
        .o_full  (full)
    );

    // Lanes 0-2 fill the staging slices; a commit leaves them intact
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_stage <= '0;
        else if (host_clear) r_stage <= '0;
        else if (host_wen && !w_commit) r_stage[{host_wsel, 5'd0} +: 32] <= host_wdata;

    // Sticky record of a commit that hit a full queue
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_overflow <= 1'b0;
        else if (host_clear) r_overflow <= 1'b0;
        else if (w_commit && full) r_overflow <= 1'b1;

    // Issue sequencer: zero-segment heads are dropped in IDLE, others issued and waited on
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_drop  <= '0;
        end else begin
            case (r_state)
                S_IDLE:
                    if (w_act) begin
                        if (w_seg_zero) begin
                            r_drop <= (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;
                        end else begin
                            r_instr <= w_head;
                            r_valid <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                S_ISSUE: begin
                    r_valid <= 1'b0;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE:
                    if (generate_done) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_cpu_instr_dispatch.sv
// tb_cpu_instr_dispatch: directed vector table plus hand-written multi-cycle sequences
module tb_cpu_instr_dispatch;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  host_wdata = '0;
    logic [1:0]   host_wsel = '0;
    logic         host_wen = 1'b0;
    logic         host_clear = 1'b0;
    logic         run = 1'b0;
    logic         generate_done = 1'b1;
    logic [127:0] instrcution;
    logic         instrc_valid;
    logic [4:0]   level;
    logic         full;
    logic         overflow;
    logic [15:0]  drop_cnt;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_instr_dispatch #(.DEPTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_wdata    (host_wdata),
        .host_wsel     (host_wsel),
        .host_wen      (host_wen),
        .host_clear    (host_clear),
        .run           (run),
        .generate_done (generate_done),
        .instrcution   (instrcution),
        .instrc_valid  (instrc_valid),
        .level         (level),
        .full          (full),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [1:0]  wsel;
        logic [31:0] wdata;
        logic        run;
        logic        gd;
        logic [4:0]  e_level;
        logic        e_valid;
        logic [15:0] e_drop;
        logic        e_busy;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] sel, input logic [31:0] data);
        host_wen   = 1'b1;
        host_wsel  = sel;
        host_wdata = data;
        tick();
        host_wen   = 1'b0;
    endtask

    task automatic commit(input logic [127:0] e);
        for (int k = 0; k < 4; k++) write_word(2'(k), e[32*k +: 32]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " instr"}, instrcution, '0);
        chk({tag, " valid"}, 128'(instrc_valid), '0);
        chk({tag, " level"}, 128'(level), '0);
        chk({tag, " full"}, 128'(full), '0);
        chk({tag, " ovf"}, 128'(overflow), '0);
        chk({tag, " drop"}, 128'(drop_cnt), '0);
        chk({tag, " busy"}, 128'(busy), '0);
    endtask

    localparam logic [127:0] EA = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_0010};
    localparam logic [127:0] EB = {32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_0030};
    localparam logic [127:0] EC = {32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_0050};

    initial begin
        vec_t tbl[11];
        int   pulses;
        logic [127:0] seen [5];

        tbl[0]  = '{1'b1, 2'd0, 32'hABC0_0021, 1'b0, 1'b1, 5'd0, 1'b0, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd1, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd0, 1'b0, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 32'h0123_4567, 1'b0, 1'b1, 5'd0, 1'b0, 16'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 32'h89AB_CDEF, 1'b1, 1'b1, 5'd1, 1'b0, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 5'd0, 1'b1, 16'd0, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 5'd0, 1'b0, 16'd0, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 5'd0, 1'b0, 16'd0, 1'b0};
        tbl[7]  = '{1'b1, 2'd0, 32'h0000_000F, 1'b0, 1'b1, 5'd0, 1'b0, 16'd0, 1'b0};
        tbl[8]  = '{1'b1, 2'd3, 32'h5A5A_5A5A, 1'b1, 1'b1, 5'd1, 1'b0, 16'd0, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 5'd0, 1'b0, 16'd1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 5'd0, 1'b0, 16'd1, 1'b0};

        repeat (2) tick();
        chk_reset_vals("reset");
        #3 rst_n = 1'b1;
        tick();

`ifndef DISPATCH_LOOP_EN
        // Assemble, issue, then drop a zero-segment entry
        for (int i = 0; i < 11; i++) begin
            host_wen   = tbl[i].wen;
            host_wsel  = tbl[i].wsel;
            host_wdata = tbl[i].wdata;
            run        = tbl[i].run;
            generate_done = tbl[i].gd;
            tick();
            chk($sformatf("v%0d level", i), 128'(level), 128'(tbl[i].e_level));
            chk($sformatf("v%0d valid", i), 128'(instrc_valid), 128'(tbl[i].e_valid));
            chk($sformatf("v%0d drop", i), 128'(drop_cnt), 128'(tbl[i].e_drop));
            chk($sformatf("v%0d busy", i), 128'(busy), 128'(tbl[i].e_busy));
            if (i == 4) chk("issued word", instrcution, {32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF, 32'hABC0_0021});
        end
        host_wen = 1'b0;
        run = 1'b0;
        chk("instr held", instrcution, {32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF, 32'hABC0_0021});

        // Executor busy for 20 cycles holds off the second issue
        commit(EA);
        commit(EB);
        chk("two queued", 128'(level), 128'd2);
        run = 1'b1;
        generate_done = 1'b1;
        tick();
        chk("A pulse", 128'(instrc_valid), 128'd1);
        chk("A word", instrcution, EA);
        generate_done = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instrc_valid) pulses++;
        end
        chk("no pulse while busy", 128'(pulses), 128'd0);
        chk("A stable", instrcution, EA);
        chk("B still queued", 128'(level), 128'd1);
        generate_done = 1'b1;
        tick();
        chk("done->idle no pulse", 128'(instrc_valid), 128'd0);
        tick();
        chk("B pulse", 128'(instrc_valid), 128'd1);
        chk("B word", instrcution, EB);
        chk("B level", 128'(level), 128'd0);
        run = 1'b0;
        repeat (3) tick();
        chk("idle again", 128'(busy), 128'd0);

        // Fill, overflow, rejected commit racing a pop, then clear
        for (int i = 0; i < 16; i++) commit({32'(i), 32'hA, 32'hB, 32'h0000_0100 | 32'(i)});
        chk("fill full", 128'(full), 128'd1);
        chk("fill level", 128'(level), 128'd16);
        chk("fill no ovf", 128'(overflow), 128'd0);
        commit(EC);
        chk("17th full", 128'(full), 128'd1);
        chk("17th ovf", 128'(overflow), 128'd1);
        chk("17th level", 128'(level), 128'd16);
        for (int k = 0; k < 3; k++) write_word(2'(k), EC[32*k +: 32]);
        run = 1'b1;
        write_word(2'd3, EC[127:96]);
        run = 1'b0;
        chk("pop+rejected level", 128'(level), 128'd15);
        chk("pop+rejected valid", 128'(instrc_valid), 128'd1);
        chk("pop+rejected head", instrcution, {32'd0, 32'hA, 32'hB, 32'h0000_0100});
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        chk("clear level", 128'(level), 128'd0);
        chk("clear full", 128'(full), 128'd0);
        chk("clear ovf", 128'(overflow), 128'd0);
        repeat (2) tick();
`endif

        // Asynchronous reset while waiting on the executor
        run = 1'b0;
        generate_done = 1'b1;
        commit(EA);
        run = 1'b1;
        tick();
        chk("pre-reset pulse", 128'(instrc_valid), 128'd1);
        generate_done = 1'b0;
        repeat (2) tick();
        chk("in wait", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async rst");
        #3 rst_n = 1'b1;
        generate_done = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (instrc_valid) pulses++;
        end
        chk("no issue after rst", 128'(pulses), 128'd0);
        chk("empty after rst", 128'(level), 128'd0);
        run = 1'b0;

`ifdef DISPATCH_LOOP_EN
        // Replay: three stored entries issue in a repeating order
        commit(EA);
        commit(EB);
        commit(EC);
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60 && pulses < 5; i++) begin
            tick();
            if (instrc_valid) begin
                seen[pulses] = instrcution;
                pulses++;
            end
        end
        run = 1'b0;
        chk("loop pulses", 128'(pulses), 128'd5);
        chk("loop 0", seen[0], EA);
        chk("loop 1", seen[1], EB);
        chk("loop 2", seen[2], EC);
        chk("loop 3", seen[3], EA);
        chk("loop 4", seen[4], EB);
        chk("loop level", 128'(level), 128'd3);
`else
        seen[0] = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
